stage_shift_buf: RTL and testbench
==================================

STAGE_SHIFT_BUF -- requirements
Module: stage_shift_buf

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 9, giving the signed sample width per real or imaginary part.
REQ-002 The block SHALL have parameter LANES, default 16, giving the samples accepted per beat; it is a power of two, at least 2.
REQ-003 The block SHALL have parameter MAX_DEPTH, default 256, giving the maximum buffer depth in samples; it is a power of two and a multiple of LANES.
REQ-004 The block SHALL have parameter SEL_W, default $clog2($clog2(MAX_DEPTH/LANES)+1), giving the depth-select width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port depth_sel, input, SEL_W bits: active depth = LANES << depth_sel.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous clear of buffer and counters.
REQ-009 The block SHALL have ports din_re and din_im, input, LANES x DATA_WIDTH signed: input samples.
REQ-010 The block SHALL have port valid, input, 1 bit: din_re/din_im carry one beat this cycle.
REQ-011 The block SHALL have ports shift_data_re and shift_data_im, output, LANES x DATA_WIDTH signed: oldest LANES samples at the active tap.
REQ-012 The block SHALL have port bfly_valid, output, 1 bit: one-cycle pulse marking a butterfly-ready window.
REQ-013 The block SHALL have port blk_cnt, output, 16 bits: count of bfly_valid pulses since the last reset or flush, wrapping.
REQ-014 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-015 The block SHALL have port cfg_err, output, 1 bit: sticky flag set by an illegal depth_sel.

Function
REQ-016 Storage SHALL be MAX_DEPTH entries per part; on each valid beat, entries shift up by LANES and din lane j is written to entry j.
REQ-017 shift_data lane k SHALL be combinational from entry (D - LANES + k), where D is the latched active depth.
REQ-018 A sample entering on valid beat n SHALL appear on shift_data after beat n + D/LANES - 1, with no extra register stage.
REQ-019 The FSM SHALL have states IDLE, FILL and RUN.
REQ-020 In IDLE, D SHALL be latched from depth_sel every cycle.
REQ-021 If LANES << depth_sel > MAX_DEPTH, D SHALL clamp to MAX_DEPTH and cfg_err SHALL be set.
REQ-022 On the first valid beat in IDLE, the FSM SHALL move to FILL and count that beat.
REQ-023 In FILL, on each valid beat, cnt SHALL increase by LANES; when cnt + LANES >= D, the block SHALL pulse bfly_valid on the next cycle, clear cnt, and enter RUN.
REQ-024 In RUN, the step count S SHALL be max(D/2, LANES); on a valid beat where cnt + LANES >= S, the block SHALL pulse bfly_valid and clear cnt, else cnt += LANES.
REQ-025 With D = LANES, the first beat SHALL produce bfly_valid, and every following beat SHALL also pulse.
REQ-026 bfly_valid SHALL be registered and high for exactly one cycle per qualifying beat; it SHALL be 0 in any cycle following a non-valid cycle.
REQ-027 When valid is low, the buffer, cnt and state SHALL hold; gaps do not restart counting.
REQ-028 blk_cnt SHALL increment in the same cycle bfly_valid is asserted, wrapping 0xFFFF -> 0.
REQ-029 depth_sel changes outside IDLE SHALL be ignored until the next IDLE.
REQ-030 flush SHALL clear all entries to 0, cnt, blk_cnt and bfly_valid, and return the FSM to IDLE next cycle; cfg_err is not cleared by flush.
REQ-031 flush SHALL take priority over valid in the same cycle; that beat is dropped.
REQ-032 cnt SHALL be $clog2(MAX_DEPTH)+1 bits wide, so cnt + LANES never overflows.

Reset
REQ-033 While rst = 1, all entries SHALL be 0, shift_data = 0, bfly_valid = 0, blk_cnt = 0, busy = 0, cfg_err = 0, and state = IDLE.
REQ-034 D SHALL reset to MAX_DEPTH.
REQ-035 rst assertion mid-FILL or mid-RUN SHALL take effect immediately, without waiting for a clock edge.
REQ-036 After rst deassertion, the first valid beat SHALL be treated as the first beat of FILL.

Verification
REQ-037 Default parameters, depth_sel = 4 (D = 256), 40 back-to-back beats with lane value = beat index: bfly_valid SHALL pulse after beats 16, 24, 32 and 40; shift_data_re lane 0 SHALL equal 0 after beat 16.
REQ-038 depth_sel = 0 (D = 16): bfly_valid SHALL pulse on every beat; shift_data SHALL equal the previous beat's din.
REQ-039 D = 64, valid toggling 1-0-1-0: bfly_valid SHALL fire only after the 4th valid beat, then after every 2nd valid beat, with no pulse in low-valid cycles.
REQ-040 flush asserted with valid at beat 10 of FILL, D = 256: all outputs SHALL be 0 next cycle, busy = 0, and the next bfly_valid SHALL come 16 beats later.
REQ-041 depth_sel = 5 with default parameters: cfg_err = 1, D = 256 behaviour; a later flush SHALL leave cfg_err = 1, and rst SHALL clear it.
REQ-042 rst pulsed between clock edges during RUN: outputs SHALL be 0 before the next edge, and blk_cnt SHALL be 0.

Source files
------------

// File: rtl/stage_shift_buf.sv
// Multi-lane complex sample shift buffer with a programmable tap depth.
// Raises a one-cycle bfly_valid each time a butterfly window is ready.
module stage_shift_buf #(
    parameter int DATA_WIDTH = 9,
    parameter int LANES      = 16,
    parameter int MAX_DEPTH  = 256,
    parameter int SEL_W      = $clog2($clog2(MAX_DEPTH/LANES)+1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SEL_W-1:0]             depth_sel,
    input  logic                         flush,
    input  logic signed [DATA_WIDTH-1:0] din_re [LANES],
    input  logic signed [DATA_WIDTH-1:0] din_im [LANES],
    input  logic                         valid,
    output logic signed [DATA_WIDTH-1:0] shift_data_re [LANES],
    output logic signed [DATA_WIDTH-1:0] shift_data_im [LANES],
    output logic                         bfly_valid,
    output logic [15:0]                  blk_cnt,
    output logic                         busy,
    output logic                         cfg_err
);
    localparam int ADDR_W  = $clog2(MAX_DEPTH);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int MAX_SEL = $clog2(MAX_DEPTH/LANES);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        d_q, d_d;
    logic                    err_d, bfly_d;
    logic [15:0]             blk_d;
    logic                    sel_bad;
    logic [CNT_W-1:0]        d_new, step, cnt_step;
    logic [ADDR_W-1:0]       tap_base;

    logic signed [DATA_WIDTH-1:0] mem_re [MAX_DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_im [MAX_DEPTH];

    assign sel_bad  = 32'(depth_sel) > MAX_SEL;
    assign d_new    = sel_bad ? MAX_C : (LANES_C << depth_sel);
    // Run-phase stride: half the window, never shorter than one beat.
    assign step     = ((d_q >> 1) < LANES_C) ? LANES_C : (d_q >> 1);
    assign cnt_step = cnt_q + LANES_C;
    assign tap_base = ADDR_W'(d_q - LANES_C);
    assign busy     = (state_q != IDLE);

    // NOTE: the storage is a flop array, so it takes the async reset; a RAM macro could not clear in zero time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else if (valid) begin
            for (int i = MAX_DEPTH - 1; i >= LANES; i--) begin
                mem_re[i] <= mem_re[i-LANES];
                mem_im[i] <= mem_im[i-LANES];
            end
            for (int j = 0; j < LANES; j++) begin
                mem_re[j] <= din_re[j];
                mem_im[j] <= din_im[j];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            shift_data_re[k] = mem_re[tap_base + ADDR_W'(k)];
            shift_data_im[k] = mem_im[tap_base + ADDR_W'(k)];
        end
    end

    // NOTE: every next-state variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        err_d   = cfg_err;
        bfly_d  = 1'b0;
        blk_d   = blk_cnt;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            blk_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    d_d = d_new;
                    if (sel_bad) err_d = 1'b1;
                    if (valid) begin
                        if (LANES_C >= d_q) begin
                            bfly_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = RUN;
                        end else begin
                            cnt_d   = LANES_C;
                            state_d = FILL;
                        end
                    end
                end
                FILL: begin
                    if (valid) begin
                        if (cnt_step >= d_q) begin
                            bfly_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_step;
                        end
                    end
                end
                RUN: begin
                    if (valid) begin
                        if (cnt_step >= step) begin
                            bfly_d = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_step;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (bfly_d) blk_d = blk_cnt + 16'd1;
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            d_q        <= MAX_C;
            cfg_err    <= 1'b0;
            bfly_valid <= 1'b0;
            blk_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_q        <= d_d;
            cfg_err    <= err_d;
            bfly_valid <= bfly_d;
            blk_cnt    <= blk_d;
        end
    end
endmodule

// File: tb/tb_stage_shift_buf.sv
// Directed bench for stage_shift_buf at default parameters (D up to 256, 16 lanes).
module tb_stage_shift_buf;
    localparam int DW = 9;
    localparam int L  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           depth_sel;
    logic                 flush;
    logic                 valid;
    logic signed [DW-1:0] din_re [L];
    logic signed [DW-1:0] din_im [L];
    logic signed [DW-1:0] shift_data_re [L];
    logic signed [DW-1:0] shift_data_im [L];
    logic                 bfly_valid;
    logic [15:0]          blk_cnt;
    logic                 busy;
    logic                 cfg_err;

    int passed = 0;
    int total  = 0;

    stage_shift_buf dut (
        .clk(clk), .rst(rst), .depth_sel(depth_sel), .flush(flush),
        .din_re(din_re), .din_im(din_im), .valid(valid),
        .shift_data_re(shift_data_re), .shift_data_im(shift_data_im),
        .bfly_valid(bfly_valid), .blk_cnt(blk_cnt), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane j carries v on re and v+j on im.
    task automatic beat(input int v);
        for (int j = 0; j < L; j++) begin
            din_re[j] = 9'(v);
            din_im[j] = 9'(v + j);
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; depth_sel = 3'd4; flush = 1'b0; valid = 1'b0;
        for (int j = 0; j < L; j++) begin
            din_re[j] = '0;
            din_im[j] = '0;
        end
        tick(); tick();
        check("rst_bfly", bfly_valid, 0);
        check("rst_blk", blk_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cfg_err, 0);
        check("rst_sd_re0", shift_data_re[0], 0);
        check("rst_sd_im15", shift_data_im[15], 0);

        // D = 256, 40 back-to-back beats, value = beat index from 0
        rst = 1'b0;
        tick(); tick();
        for (int i = 0; i < 40; i++) begin
            beat(i);
            check($sformatf("d256_bfly_b%0d", i + 1), bfly_valid,
                  ((i + 1) == 16 || (i + 1) == 24 || (i + 1) == 32 || (i + 1) == 40) ? 1 : 0);
            if (i == 0)  check("d256_busy", busy, 1);
            if (i == 15) begin
                check("d256_sd_re0_b16", shift_data_re[0], 0);
                check("d256_sd_im5_b16", shift_data_im[5], 5);
            end
            if (i == 16) check("d256_sd_re0_b17", shift_data_re[0], 1);
        end
        tick();
        check("d256_gap_bfly", bfly_valid, 0);
        check("d256_blk", blk_cnt, 4);
        check("d256_sd_hold", shift_data_re[0], 24);

        // flush with valid on FILL beat 10
        flush = 1'b1; tick(); flush = 1'b0;
        check("fl_busy", busy, 0);
        check("fl_blk", blk_cnt, 0);
        for (int i = 0; i < 9; i++) beat(50 + i);
        check("fl_fill_busy", busy, 1);
        flush = 1'b1; beat(59); flush = 1'b0;
        check("fl2_bfly", bfly_valid, 0);
        check("fl2_blk", blk_cnt, 0);
        check("fl2_busy", busy, 0);
        check("fl2_err", cfg_err, 0);
        check("fl2_sd_re0", shift_data_re[0], 0);
        check("fl2_sd_im15", shift_data_im[15], 0);
        for (int i = 0; i < 16; i++) begin
            beat(100 + i);
            check($sformatf("fl_bfly_b%0d", i + 1), bfly_valid, (i == 15) ? 1 : 0);
        end
        check("fl_sd_re0", shift_data_re[0], 100);

        // D = 16: every beat pulses, tap shows the beat just taken
        depth_sel = 3'd0; flush = 1'b1; tick(); flush = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            beat(-50 + 10 * i);
            check($sformatf("d16_bfly_b%0d", i + 1), bfly_valid, 1);
            check($sformatf("d16_re3_b%0d", i + 1), shift_data_re[3], -50 + 10 * i);
            check($sformatf("d16_im7_b%0d", i + 1), shift_data_im[7], -50 + 10 * i + 7);
            check($sformatf("d16_blk_b%0d", i + 1), blk_cnt, i + 1);
        end

        // D = 64 with valid toggling; depth_sel change mid-run must be ignored
        depth_sel = 3'd2; flush = 1'b1; tick(); flush = 1'b0;
        tick();
        for (int v = 1; v <= 10; v++) begin
            beat(3 * v);
            check($sformatf("d64_bfly_v%0d", v), bfly_valid, (v == 4 || v == 6 || v == 8 || v == 10) ? 1 : 0);
            if (v == 4) check("d64_sd_re0_v4", shift_data_re[0], 3);
            if (v == 5) depth_sel = 3'd0;
            tick();
            check($sformatf("d64_gap_v%0d", v), bfly_valid, 0);
        end
        check("d64_blk", blk_cnt, 4);

        // illegal depth_sel clamps to 256 and sets sticky cfg_err
        depth_sel = 3'd5; flush = 1'b1; tick(); flush = 1'b0;
        tick();
        check("err_set", cfg_err, 1);
        for (int i = 0; i < 16; i++) begin
            beat(i);
            check($sformatf("err_bfly_b%0d", i + 1), bfly_valid, (i == 15) ? 1 : 0);
        end
        depth_sel = 3'd4; flush = 1'b1; tick(); flush = 1'b0;
        check("err_after_flush", cfg_err, 1);
        rst = 1'b1; #1;
        check("err_after_rst", cfg_err, 0);
        tick();

        // rst pulsed between edges during RUN
        rst = 1'b0; depth_sel = 3'd0;
        tick();
        for (int i = 0; i < 3; i++) beat(20 + i);
        check("run_blk", blk_cnt, 3);
        check("run_bfly", bfly_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_bfly", bfly_valid, 0);
        check("arst_blk", blk_cnt, 0);
        check("arst_busy", busy, 0);
        check("arst_sd_re0", shift_data_re[0], 0);
        tick();
        rst = 1'b0;
        tick();
        beat(7);
        check("post_rst_bfly", bfly_valid, 1);
        check("post_rst_blk", blk_cnt, 1);
        check("post_rst_sd", shift_data_re[9], 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
